// File: rtl/vert_pkg.sv
// Shared constants and FSM state type for the vertex transform pipeline.
package vert_pkg;

  localparam int unsigned ANGLE_W   = 9;
  localparam int unsigned ANGLE_MAX = 359;
  localparam int unsigned TRIG_FRAC = 10;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StCalc,
    StEmit
  } state_e;

endpackage

// File: rtl/vert_transform_if.sv
// Transformed-vertex stream towards the rasterizer (valid/ready handshake).
interface vert_transform_if #(
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned SCREEN_W = 10
);

  logic                out_valid;
  logic                out_ready;
  logic [IDX_W-1:0]    out_idx;
  logic [SCREEN_W-1:0] out_x;
  logic [SCREEN_W-1:0] out_y;
  logic                out_last;

  modport master (
    output out_valid,
    output out_idx,
    output out_x,
    output out_y,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_x,
    input  out_y,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/angle_ticker.sv
// Rotation-angle ticker: steps 0..359 once per TICK_PERIOD cycles, deferring
// steps that land while frozen and collapsing them into a single step.
module angle_ticker
  import vert_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = 333334
) (
  input  logic               clk_pix,
  input  logic               rst_n,
  input  logic               freeze,
  output logic [ANGLE_W-1:0] angle
);

  localparam int unsigned CNT_W = $clog2(TICK_PERIOD);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic               pending_q, pending_d;
  logic               wrap;
  logic               step;

  always_comb begin
    wrap      = (cnt_q == CNT_W'(TICK_PERIOD - 1));
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    step      = !freeze && (wrap || pending_q);
    // A wrap coinciding with a pending step still yields only one step.
    pending_d = freeze ? (pending_q || wrap) : 1'b0;
    angle_d   = angle_q;
    if (step) begin
      angle_d = (angle_q == ANGLE_W'(ANGLE_MAX)) ? '0 : angle_q + 1'b1;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      angle_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      angle_q   <= angle_d;
      pending_q <= pending_d;
    end
  end

  assign angle = angle_q;

endmodule

// File: rtl/vert_transform.sv
// Streams NUM_VERTS vertices from ROM, rotates by a frozen angle, and emits
// screen coordinates. Define VERT_TRANSFORM_CLAMP_EN to saturate instead of wrap.
module vert_transform
  import vert_pkg::*;
#(
  parameter int unsigned NUM_VERTS   = 3,
  parameter int unsigned COORD_W     = 8,
  parameter int unsigned TRIG_W      = 12,
  parameter int unsigned SCREEN_W    = 10,
  parameter int unsigned CENTER_X    = 320,
  parameter int unsigned CENTER_Y    = 240,
  parameter int unsigned TICK_PERIOD = 333334,
  localparam int unsigned IDX_W      = (NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1
) (
  input  logic                      clk_pix,
  input  logic                      rst_n,
  output logic [ANGLE_W-1:0]        angle,
  input  logic signed [TRIG_W-1:0]  sin,
  input  logic signed [TRIG_W-1:0]  cos,
  output logic [IDX_W-1:0]          vert_addr,
  input  logic signed [COORD_W-1:0] vert_x,
  input  logic signed [COORD_W-1:0] vert_y,
  input  logic                      start,
  output logic                      busy,
  vert_transform_if.master          vout
);

  localparam int unsigned PROD_W = COORD_W + TRIG_W + 1;
  localparam int unsigned SUM_W  = SCREEN_W + 2;

  state_e                    state_q, state_d;
  logic                      busy_q, busy_d;
  logic [IDX_W-1:0]          addr_q, addr_d;
  logic signed [TRIG_W-1:0]  sin_q, sin_d, cos_q, cos_d;
  logic                      valid_q, valid_d, last_q, last_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [SCREEN_W-1:0]       x_q, x_d, y_q, y_d;
  logic                      start_acc;

  logic signed [PROD_W-1:0]  xc, ys, xs, yc, rx_full, ry_full;
  logic signed [SUM_W-1:0]   sx, sy;
  logic [SCREEN_W-1:0]       px, py;

  angle_ticker #(
    .TICK_PERIOD (TICK_PERIOD)
  ) u_ticker (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .freeze  (busy_q || start_acc),
    .angle   (angle)
  );

`ifdef VERT_TRANSFORM_CLAMP_EN
  function automatic logic [SCREEN_W-1:0] fit(logic signed [SUM_W-1:0] v);
    if (v < 0) return '0;
    if (v > $signed(SUM_W'({SCREEN_W{1'b1}}))) return '1;
    return SCREEN_W'(v);
  endfunction
`else
  function automatic logic [SCREEN_W-1:0] fit(logic signed [SUM_W-1:0] v);
    return SCREEN_W'(v);
  endfunction
`endif

  always_comb begin
    xc      = $signed(PROD_W'(vert_x)) * $signed(PROD_W'(cos_q));
    ys      = $signed(PROD_W'(vert_y)) * $signed(PROD_W'(sin_q));
    xs      = $signed(PROD_W'(vert_x)) * $signed(PROD_W'(sin_q));
    yc      = $signed(PROD_W'(vert_y)) * $signed(PROD_W'(cos_q));
    rx_full = xc - ys;
    ry_full = xs + yc;
    sx      = $signed(SUM_W'(rx_full >>> TRIG_FRAC)) + $signed(SUM_W'(CENTER_X));
    sy      = $signed(SUM_W'(ry_full >>> TRIG_FRAC)) + $signed(SUM_W'(CENTER_Y));
    px      = fit(sx);
    py      = fit(sy);
  end

  assign start_acc = (state_q == StIdle) && start;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
    valid_d = valid_q;
    last_d  = last_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          busy_d  = 1'b1;
          addr_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // Trig is latched once per batch so every vertex shares one angle.
        if (addr_q == '0) begin
          sin_d = sin;
          cos_d = cos;
        end
        state_d = StCalc;
      end
      StCalc: begin
        x_d     = px;
        y_d     = py;
        idx_d   = addr_q;
        last_d  = (addr_q == IDX_W'(NUM_VERTS - 1));
        valid_d = 1'b1;
        state_d = StEmit;
      end
      StEmit: begin
        if (vout.out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign busy          = busy_q;
  assign vert_addr     = addr_q;
  assign vout.out_valid = valid_q;
  assign vout.out_idx   = idx_q;
  assign vout.out_x     = x_q;
  assign vout.out_y     = y_q;
  assign vout.out_last  = last_q;

endmodule

// File: doc/vert_transform.md
Name: vert_transform

Overview:
Parametrised successor to the fixed three-vertex shader. Streams NUM_VERTS model-space vertices from an external vertex ROM and applies a full 2D rotation with sin and cos. Translates each result to a screen centre and emits it to the rasterizer over a valid/ready handshake. Owns the rotation-angle ticker and freezes the angle while a batch is in flight, so all vertices of a frame share one angle.

Parameters:
NUM_VERTS, 3, vertices per batch (≥1); IDX_W = max(1, clog2(NUM_VERTS))
COORD_W, 8, signed model-coordinate width
TRIG_W, 12, signed sin/cos width, Q1.10 (1.0 = 1024)
SCREEN_W, 10, unsigned screen-coordinate width
CENTER_X, 320, screen-x translation
CENTER_Y, 240, screen-y translation
TICK_PERIOD, 333334, clk_pix cycles per angle step (≥2)

Ports:
clk_pix  in  1  pixel clock, all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
angle  out  9  degrees 0..359, drives external sin/cos LUT
sin  in  TRIG_W  signed Q1.10, valid 1 cycle after angle changes
cos  in  TRIG_W  signed Q1.10, same timing as sin
vert_addr  out  IDX_W  vertex ROM address
vert_x  in  COORD_W  signed, valid 1 cycle after vert_addr
vert_y  in  COORD_W  signed, same timing
start  in  1  per-frame batch request pulse
busy  out  1  high from start acceptance to last handshake
out_valid  out  1  transformed vertex available
out_ready  in  1  rasterizer accepts
out_idx  out  IDX_W  vertex index
out_x  out  SCREEN_W  screen x
out_y  out  SCREEN_W  screen y
out_last  out  1  marks index NUM_VERTS-1

Behaviour:
- Reset (async, rst_n=0): angle=0, tick count=0, pending=0, state IDLE, busy=0, out_valid=0, vert_addr=0, out_idx/out_x/out_y/out_last=0.
- Ticker:
  - Counter runs 0..TICK_PERIOD-1 continuously.
  - At the wrap, if not frozen, angle steps by one; 359 wraps to 0. If frozen, pending is set instead.
  - Frozen = busy, or start accepted this cycle.
  - The first unfrozen cycle with pending=1 applies exactly one step and clears pending. Multiple ticks while frozen collapse into one step.
- FSM states: IDLE, FETCH, CALC, EMIT.
  - IDLE: start=1 → busy<=1, vert_addr<=0, go to FETCH. start is ignored in all other states.
  - FETCH (1 cycle): ROM data arrives. sin/cos captured into trig registers on the vertex-0 FETCH only. → CALC.
  - CALC (1 cycle):
    - rx = (x·cos − y·sin) >>> 10 and ry = (x·sin + y·cos) >>> 10.
    - Products are full width COORD_W+TRIG_W+1; shift is arithmetic.
    - Add CENTER_X / CENTER_Y at SCREEN_W+2 signed width, then truncate modulo 2^SCREEN_W.
    - Registers the out_* fields and sets out_valid=1. → EMIT.
  - EMIT: out_* held stable while out_valid && !out_ready. On handshake:
    - If not the last vertex: out_valid<=0, vert_addr++, → FETCH.
    - Else: out_valid<=0, busy<=0, → IDLE.
- Latency: start accepted at cycle T → out_valid at T+3. Per-vertex throughput is 3 cycles with out_ready held high.
- Reset mid-batch aborts immediately with no partial output. The next start restarts at index 0.

Optional Feature:
VERT_TRANSFORM_CLAMP_EN
- Defined: out_x and out_y saturate to [0, 2^SCREEN_W−1] instead of wrapping.
- Undefined: modulo wrap as specified in Behaviour.

Decomposition:
- Package vert_pkg: ANGLE_W=9, ANGLE_MAX=359, TRIG_FRAC=10, FSM state enum.
- One sub-module, angle_ticker: period counter, angle register, freeze/pending logic.

Test Plan:
- Reset with rst_n=0 asynchronously → angle=0, busy=0, out_valid=0 before the next clock edge.
- TICK_PERIOD=4, no start → angle increments every 4 cycles; after 360 steps angle returns to 0.
- cos=1024, sin=0, vertices (0,−120),(−100,120),(100,120), out_ready=1 → (320,120),(220,360),(420,360); idx 0,1,2; out_last only on idx 2; out_valid at start+3, +6, +9.
- cos=0, sin=1024, vertex (10,0) → out (320,250); vertex (0,10) → out (310,240).
- out_ready=0 for 5 cycles in EMIT → out_* and out_valid stable; two tick wraps during the batch → angle advances exactly once, on the cycle after busy falls.
- CENTER_X=100, vertex (−128,0), cos=1024 → out_x=996 without macro, 0 with VERT_TRANSFORM_CLAMP_EN. Assert rst_n low mid-EMIT → out_valid=0 and busy=0 immediately.
